// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated ALU: FSM state encoding,
// ALU op codes and the two-port grant function.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_SUB  = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_OR   = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_SLL  = 3'd5;
    localparam op_t OP_SRL  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    // One-hot grant for two ports. last_grant = 1 means port 1 won last time,
    // so port 0 wins the next contention; fixed-priority mode always favours port 0.
    function automatic logic [1:0] arb_grant(input logic [1:0] valid,
                                             input logic       last_grant,
                                             input logic       rr_en);
        logic [1:0] g;
        case (valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11: begin
                if (rr_en && !last_grant) begin
                    g = 2'b10;
                end else begin
                    g = 2'b01;
                end
            end
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU. Cout is the adder carry for ADD and the
// no-borrow carry (a + ~b + 1) for SUB; it is 0 for logic and shift ops.
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  op_t         op_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        cout_o
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;

    // Arithmetic, logic and shift evaluation of the latched operands
    always_comb begin
        sum_s    = {1'b0, a_i} + {1'b0, b_i};
        diff_s   = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
        result_o = 32'd0;
        cout_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum_s[31:0];
                cout_o   = sum_s[32];
            end
            OP_SUB: begin
                result_o = diff_s[31:0];
                cout_o   = diff_s[32];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << b_i[4:0];
            OP_SRL:  result_o = a_i >> b_i[4:0];
            OP_PASS: result_o = a_i;
            default: result_o = 32'd0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single 32-bit ALU. One operation is in
// flight at a time: IDLE accepts a request, EXEC evaluates and registers the
// result, RESP holds it for the owning port until that port accepts it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_e           state_q, state_d;
    logic [31:0]      a_q, b_q;
    op_t              op_q;
    logic             port_q;
    logic             last_grant_q;
    logic [31:0]      result_q;
    logic             zero_q, cout_q;
    logic [CNT_W-1:0] ops_done_q;

    logic [1:0]       grant_s;
    logic             accept_s;
    logic             rsp_hs_s;
    logic [31:0]      alu_result_s;
    logic             alu_zero_s, alu_cout_s;

    alu32 u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result_s),
        .zero_o   (alu_zero_s),
        .cout_o   (alu_cout_s)
    );

    // Arbitration and handshake detection
    always_comb begin
        grant_s  = arb_grant(req_valid, last_grant_q, RR_EN != 0);
        accept_s = (state_q == ST_IDLE) && (grant_s != 2'b00);
        rsp_hs_s = (state_q == ST_RESP) && rsp_ready[port_q];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request accept only in IDLE, response valid only to the owner
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = grant_s;
            ST_EXEC: busy = 1'b1;
            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = port_q ? 2'b10 : 2'b01;
            end
            default: busy = 1'b0;
        endcase
    end

    // Latch the granted port's operands and remember who won
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= OP_ADD;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept_s) begin
            a_q          <= grant_s[1] ? req_a1  : req_a0;
            b_q          <= grant_s[1] ? req_b1  : req_b0;
            op_q         <= grant_s[1] ? req_op1 : req_op0;
            port_q       <= grant_s[1];
            last_grant_q <= grant_s[1];
        end
    end

    // Capture ALU result and flags at the end of EXEC; held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_result_s;
            zero_q   <= alu_zero_s;
            cout_q   <= alu_cout_s;
        end
    end

    // Completed-response counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done_q <= {CNT_W{1'b0}};
        end else if (rsp_hs_s) begin
            ops_done_q <= ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_cout   = cout_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: one round-robin and one fixed-priority
// instance share request inputs; a scoreboard records the expected response at
// each request accept and compares it when the round-robin instance responds.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  rsp_ready_rr, rsp_ready_fp;

    logic [1:0]  rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
    logic [31:0] rr_result, fp_result;
    logic        rr_zero, rr_cout, fp_zero, fp_cout, rr_busy, fp_busy;
    logic [15:0] rr_ops, fp_ops;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        z;
        logic        c;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.RR_EN(1), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rr_rsp_valid),
        .rsp_ready(rsp_ready_rr), .rsp_result(rr_result), .rsp_zero(rr_zero),
        .rsp_cout(rr_cout), .busy(rr_busy), .ops_done(rr_ops)
    );

    alu_arbiter #(.RR_EN(0), .CNT_W(16)) u_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(fp_rsp_valid),
        .rsp_ready(rsp_ready_fp), .rsp_result(fp_result), .rsp_zero(fp_zero),
        .rsp_cout(fp_cout), .busy(fp_busy), .ops_done(fp_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {cout, zero, result}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] r;
        logic        c;
        longint      s;
        c = 1'b0;
        case (op)
            3'd0: begin
                s = longint'(a) + longint'(b);
                r = a + b;
                c = (s > 64'sd4294967295);
            end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = a;
        endcase
        return {c, (r == 32'd0), r};
    endfunction

    // Advance to the falling edge and run the scoreboard on the RR instance
    task automatic tick();
        exp_t        e;
        logic [33:0] m;
        logic [1:0]  ev;
        @(negedge clk);
        if (!rst) begin
            if ((req_valid & rr_req_ready) != 2'b00) begin
                e.port = rr_req_ready[1];
                m = rr_req_ready[1] ? model(req_a1, req_b1, req_op1)
                                    : model(req_a0, req_b0, req_op0);
                e.c = m[33]; e.z = m[32]; e.res = m[31:0];
                sb.push_back(e);
            end
            if ((rr_rsp_valid & rsp_ready_rr) != 2'b00) begin
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: rsp_valid=%b with no outstanding request", rr_rsp_valid);
                end else begin
                    e  = sb.pop_front();
                    ev = e.port ? 2'b10 : 2'b01;
                    if (rr_rsp_valid !== ev || rr_result !== e.res || rr_zero !== e.z || rr_cout !== e.c) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got valid=%b res=%h z=%b c=%b, expected valid=%b res=%h z=%b c=%b",
                                 rr_rsp_valid, rr_result, rr_zero, rr_cout, ev, e.res, e.z, e.c);
                    end
                end
            end
        end
    endtask

    // Step to just after the next rising edge for input changes
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready_rr = 2'b11;
        rsp_ready_fp = 2'b11;
        drive_edge();
        drive_edge();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
        req_op0 = OP_ADD; req_op1 = OP_ADD;
        rsp_ready_rr = 2'b11; rsp_ready_fp = 2'b11;
        tick();
        n_run++;
        if (rr_rsp_valid !== 2'b00 || rr_busy !== 1'b0 || rr_ops !== 16'd0 ||
            rr_result !== 32'd0 || rr_zero !== 1'b0 || rr_cout !== 1'b0 || rr_req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: vld=%b busy=%b ops=%0d res=%h z=%b c=%b rdy=%b, expected all zero",
                     rr_rsp_valid, rr_busy, rr_ops, rr_result, rr_zero, rr_cout, rr_req_ready);
        end
        req_valid = 2'b11;
        #1;
        n_run++;
        if (rr_req_ready !== 2'b01 || fp_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: rr=%b fp=%b, expected 01", rr_req_ready, fp_req_ready);
        end
        req_valid = 2'b00;
        drive_edge();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        do_reset();
        req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = OP_ADD;
        req_valid = 2'b01;
        rsp_ready_rr = 2'b01;
        tick();
        n_run++;
        if (rr_req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b, expected 01", rr_req_ready);
        end
        drive_edge();
        req_valid = 2'b00;
        tick();
        n_run++;
        if (rr_busy !== 1'b1 || rr_rsp_valid !== 2'b00 || rr_req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL single_exec: busy=%b vld=%b rdy=%b, expected 1 00 00", rr_busy, rr_rsp_valid, rr_req_ready);
        end
        tick();
        n_run++;
        if (rr_rsp_valid !== 2'b01 || rr_result !== 32'd8 || rr_zero !== 1'b0 || rr_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: vld=%b res=%h z=%b c=%b, expected 01 8 0 0", rr_rsp_valid, rr_result, rr_zero, rr_cout);
        end
        drive_edge();
        tick();
        n_run++;
        if (rr_busy !== 1'b0 || rr_ops !== 16'd1 || rr_rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done: busy=%b ops=%0d vld=%b, expected 0 1 00", rr_busy, rr_ops, rr_rsp_valid);
        end
    endtask

    task automatic test_contention(input bit use_rr);
        logic [1:0] got;
        logic [1:0] exp;
        bit         found;
        do_reset();
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = OP_ADD;
        req_a1 = 32'd7; req_b1 = 32'd7; req_op1 = OP_SUB;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            got = 2'b00;
            for (int t = 0; t < 10 && !found; t++) begin
                tick();
                got = use_rr ? rr_req_ready : fp_req_ready;
                if (got != 2'b00) found = 1'b1;
            end
            exp = (use_rr && k[0]) ? 2'b10 : 2'b01;
            n_run++;
            if (!found || got !== exp) begin
                n_fail++;
                $display("FAIL %s_grant%0d: got %b, expected %b", use_rr ? "rr" : "fp", k, got, exp);
            end
            drive_edge();
            if (k == 3) req_valid = 2'b00;
        end
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            if (!rr_busy && !fp_busy) found = 1'b1;
        end
        n_run++;
        if (!found || (use_rr ? rr_ops : fp_ops) !== 16'd4) begin
            n_fail++;
            $display("FAIL %s_ops_done: got %0d, expected 4", use_rr ? "rr" : "fp", use_rr ? rr_ops : fp_ops);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = OP_ADD;
        req_valid = 2'b10;
        tick();
        n_run++;
        if (rr_req_ready !== 2'b10) begin
            n_fail++; $display("FAIL ovf_grant: got %b, expected 10", rr_req_ready);
        end
        drive_edge();
        req_valid = 2'b00;
        tick();
        tick();
        n_run++;
        if (rr_rsp_valid !== 2'b10 || rr_result !== 32'd0 || rr_zero !== 1'b1 || rr_cout !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_rsp: vld=%b res=%h z=%b c=%b, expected 10 0 1 1", rr_rsp_valid, rr_result, rr_zero, rr_cout);
        end
        drive_edge();
    endtask

    task automatic test_backpressure();
        logic [33:0] m;
        bit          found;
        do_reset();
        rsp_ready_rr = 2'b00;
        req_a0 = 32'h0F0F_0000; req_b0 = 32'h00FF_FF00; req_op0 = OP_XOR;
        req_valid = 2'b01;
        m = model(32'h0F0F_0000, 32'h00FF_FF00, 3'd4);
        tick();
        drive_edge();
        req_valid = 2'b10;
        req_a1 = 32'd100; req_b1 = 32'd30; req_op1 = OP_SUB;
        tick();
        n_run++;
        if (rr_req_ready !== 2'b00) begin
            n_fail++; $display("FAIL bp_exec_ready: got %b, expected 00", rr_req_ready);
        end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                drive_edge();
                rsp_ready_rr = (i <= 5) ? 2'b00 : 2'b10;
                req_a1 = 32'd100 + 32'(i);
            end
            tick();
            n_run++;
            if (rr_rsp_valid !== 2'b01 || rr_result !== m[31:0] || rr_req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b res=%h rdy=%b, expected 01 %h 00",
                         i, rr_rsp_valid, rr_result, rr_req_ready, m[31:0]);
            end
        end
        drive_edge();
        rsp_ready_rr = 2'b01;
        req_a1 = 32'd200;
        tick();
        drive_edge();
        tick();
        n_run++;
        if (rr_rsp_valid !== 2'b00 || rr_req_ready !== 2'b10 || rr_ops !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b ops=%0d, expected 00 10 1", rr_rsp_valid, rr_req_ready, rr_ops);
        end
        drive_edge();
        req_valid = 2'b00;
        rsp_ready_rr = 2'b11;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (!rr_busy) found = 1'b1;
        end
        n_run++;
        if (!found || rr_ops !== 16'd2) begin
            n_fail++; $display("FAIL bp_ops_done: got %0d, expected 2", rr_ops);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        req_a0 = 32'd10; req_b0 = 32'd20; req_op0 = OP_ADD;
        req_valid = 2'b01;
        tick();
        drive_edge();
        req_valid = 2'b00;
        tick();
        n_run++;
        if (rr_busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_exec: busy=%b, expected 1", rr_busy);
        end
        #1 rst = 1'b1;
        #1;
        sb.delete();
        n_run++;
        if (rr_busy !== 1'b0 || rr_rsp_valid !== 2'b00 || rr_ops !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: busy=%b vld=%b ops=%0d, expected 0 00 0", rr_busy, rr_rsp_valid, rr_ops);
        end
        drive_edge();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (rr_rsp_valid !== 2'b00 || rr_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: vld=%b busy=%b, expected 00 0", i, rr_rsp_valid, rr_busy);
            end
        end
        drive_edge();
        req_a1 = 32'd3; req_b1 = 32'd4; req_op1 = OP_ADD;
        req_valid = 2'b10;
        tick();
        drive_edge();
        req_valid = 2'b00;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (!rr_busy) found = 1'b1;
        end
        n_run++;
        if (!found || rr_ops !== 16'd1) begin
            n_fail++; $display("FAIL rstmid_next: ops=%0d, expected 1", rr_ops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention(1'b1);
        test_contention(1'b0);
        test_overflow();
        test_backpressure();
        test_reset_mid();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d responses never seen, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
